// File: rtl/pacman_pkg.sv
// Shared Pac-Man board definitions: dimensions, pellet layout and tracker states.
// Maps are indexed [row][column]; bit x of a row word is column x.
package pacman_pkg;

  localparam int COLS    = 21;
  localparam int ROWS    = 23;
  localparam int SPAWN_X = 10;
  localparam int SPAWN_Y = 12;

  // Odd rows are open corridors, even rows carry pellets only on the posts.
  localparam logic [COLS-1:0] ROW_OPEN = 21'h0FFFFE;
  localparam logic [COLS-1:0] ROW_POST = 21'h088A22;
  localparam logic [COLS-1:0] ROW_EDGE = 21'h080002;

  localparam logic [COLS-1:0] PELLET_MAP [ROWS] = '{
    '0,
    ROW_OPEN, ROW_POST & ~ROW_EDGE, ROW_OPEN, ROW_POST, ROW_OPEN,
    ROW_POST, ROW_OPEN, ROW_POST, ROW_OPEN, ROW_POST,
    ROW_OPEN, ROW_POST, ROW_OPEN, ROW_POST, ROW_OPEN,
    ROW_POST, ROW_OPEN & ~ROW_EDGE, ROW_POST, ROW_OPEN, ROW_POST,
    ROW_OPEN,
    '0
  };

  localparam logic [COLS-1:0] POWER_MAP [ROWS] = '{
    '0, '0, ROW_EDGE, '0, '0, '0, '0, '0, '0, '0, '0, '0,
    '0, '0, '0, '0, '0, ROW_EDGE, '0, '0, '0, '0, '0
  };

  // 11 open rows x 19 cells + 10 post rows x 6 cells, power pellets included.
  localparam int TOTAL_PELLETS = 269;

  typedef enum logic [1:0] {
    PLAY,
    POWER,
    CLEAR
  } tracker_state_t;

endpackage

// File: rtl/power_timer.sv
// Frightened-mode countdown: load to TICKS, count down one per tick, force clear.
// active stays high while at least one more tick remains after the current one.
module power_timer #(
  parameter int TICKS = 40,
  parameter int W     = 6
) (
  input  logic         clk2,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic         tick,
  output logic [W-1:0] remaining,
  output logic         active
);

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      remaining <= '0;
    end else if (clear) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= W'(TICKS);
    end else if (tick && (remaining != '0)) begin
      remaining <= remaining - W'(1);
    end
  end

  assign active = (remaining > W'(1));

endmodule

// File: rtl/pellet_tracker.sv
// Live pellet map, score and level state downstream of the Pac-Man movement controller.
// Every eat takes effect on the clk2 edge that samples the position.
module pellet_tracker
  import pacman_pkg::*;
#(
  parameter int PELLET_PTS  = 10,
  parameter int POWER_PTS   = 50,
  parameter int POWER_TICKS = 40,
  parameter int SCORE_W     = 16
) (
  input  logic               clk2,
  input  logic               reset,
  input  logic [4:0]         curr_x,
  input  logic [4:0]         curr_y,
  input  logic               next_level,
  input  logic [4:0]         rd_row,
  output logic [COLS-1:0]    rd_pellets,
  output logic [SCORE_W-1:0] score,
  output logic [8:0]         pellets_left,
  output logic               eat_pulse,
  output logic               power_mode,
  output logic [5:0]         power_remaining,
  output logic               level_clear
);

  localparam logic [8:0] FULL_COUNT = 9'(TOTAL_PELLETS);

  tracker_state_t  state, state_nxt;
  logic [COLS-1:0] map [ROWS];
  logic            in_range, cell_live, on_power;
  logic            eat, last_eat, reload, timer_active;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

  always_comb begin
    in_range  = (curr_x < 5'(COLS)) && (curr_y < 5'(ROWS));
    cell_live = 1'b0;
    on_power  = 1'b0;
    if (in_range) begin
      cell_live = map[curr_y][curr_x];
      on_power  = POWER_MAP[curr_y][curr_x];
    end
  end

  assign eat      = (state != CLEAR) && cell_live;
  assign last_eat = eat && (pellets_left == 9'd1);
  assign reload   = (state == CLEAR) && next_level;

  assign rd_pellets = (rd_row < 5'(ROWS)) ? map[rd_row] : '0;

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) map[r] <= PELLET_MAP[r] | POWER_MAP[r];
    end else if (reload) begin
      for (int r = 0; r < ROWS; r++) map[r] <= PELLET_MAP[r] | POWER_MAP[r];
    end else if (eat) begin
      map[curr_y][curr_x] <= 1'b0;
    end
  end

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      score        <= '0;
      pellets_left <= FULL_COUNT;
      eat_pulse    <= 1'b0;
    end else begin
      eat_pulse <= eat;
      if (reload) begin
        pellets_left <= FULL_COUNT;
      end else if (eat) begin
        pellets_left <= pellets_left - 9'd1;
        score        <= sat_add(score, on_power ? SCORE_W'(POWER_PTS) : SCORE_W'(PELLET_PTS));
      end
    end
  end

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) state <= PLAY;
    else       state <= state_nxt;
  end

  // Clearing the board outranks entering or extending frightened mode.
  always_comb begin
    state_nxt = state;
    case (state)
      PLAY: begin
        if (last_eat)             state_nxt = CLEAR;
        else if (eat && on_power) state_nxt = POWER;
      end
      POWER: begin
        if (last_eat)                             state_nxt = CLEAR;
        else if (!(eat && on_power) && !timer_active) state_nxt = PLAY;
      end
      CLEAR: begin
        if (next_level) state_nxt = PLAY;
      end
      default: state_nxt = PLAY;
    endcase
  end

  power_timer #(
    .TICKS (POWER_TICKS),
    .W     (6)
  ) u_power_timer (
    .clk2      (clk2),
    .reset     (reset),
    .load      (eat && on_power && !last_eat),
    .clear     (last_eat),
    .tick      (state == POWER),
    .remaining (power_remaining),
    .active    (timer_active)
  );

  assign power_mode  = (state == POWER);
  assign level_clear = (state == CLEAR);

endmodule

// File: tb/tb_pellet_tracker.sv
// Directed and randomized bench for pellet_tracker against a cell-level game model.
module tb_pellet_tracker;
  import pacman_pkg::*;

  localparam int SCORE_W     = 16;
  localparam int PELLET_PTS  = 10;
  localparam int POWER_PTS   = 50;
  localparam int POWER_TICKS = 40;
  localparam int SCORE_MAX   = (1 << SCORE_W) - 1;

  logic               clk2 = 1'b0;
  logic               clk_en = 1'b1;
  logic               reset = 1'b0;
  logic [4:0]         curr_x = 5'(SPAWN_X);
  logic [4:0]         curr_y = 5'(SPAWN_Y);
  logic               next_level = 1'b0;
  logic [4:0]         rd_row = 5'd0;
  logic [COLS-1:0]    rd_pellets;
  logic [SCORE_W-1:0] score;
  logic [8:0]         pellets_left;
  logic               eat_pulse;
  logic               power_mode;
  logic [5:0]         power_remaining;
  logic               level_clear;

  pellet_tracker #(
    .PELLET_PTS  (PELLET_PTS),
    .POWER_PTS   (POWER_PTS),
    .POWER_TICKS (POWER_TICKS),
    .SCORE_W     (SCORE_W)
  ) dut (
    .clk2            (clk2),
    .reset           (reset),
    .curr_x          (curr_x),
    .curr_y          (curr_y),
    .next_level      (next_level),
    .rd_row          (rd_row),
    .rd_pellets      (rd_pellets),
    .score           (score),
    .pellets_left    (pellets_left),
    .eat_pulse       (eat_pulse),
    .power_mode      (power_mode),
    .power_remaining (power_remaining),
    .level_clear     (level_clear)
  );

  always #5 if (clk_en) clk2 = ~clk2;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference game state: board bits, score, pellets left, frightened cycles left.
  logic [COLS-1:0] ref_map [ROWS];
  int ref_score, ref_left, ref_rem, ref_total;
  bit ref_clear, ref_pulse;

  function automatic void ref_reset();
    for (int r = 0; r < ROWS; r++) ref_map[r] = PELLET_MAP[r] | POWER_MAP[r];
    ref_score = 0;
    ref_left  = ref_total;
    ref_rem   = 0;
    ref_clear = 1'b0;
    ref_pulse = 1'b0;
  endfunction

  function automatic void ref_step(input int x, input int y, input bit nl);
    bit eat, pow;
    eat = 1'b0;
    pow = 1'b0;
    if (!ref_clear && x < COLS && y < ROWS) begin
      eat = ref_map[y][x];
      pow = POWER_MAP[y][x];
    end
    ref_pulse = eat;
    if (ref_clear) begin
      if (nl) begin
        for (int r = 0; r < ROWS; r++) ref_map[r] = PELLET_MAP[r] | POWER_MAP[r];
        ref_left  = ref_total;
        ref_clear = 1'b0;
      end
    end else if (eat) begin
      ref_map[y][x] = 1'b0;
      ref_left  = ref_left - 1;
      ref_score = ref_score + (pow ? POWER_PTS : PELLET_PTS);
      if (ref_score > SCORE_MAX) ref_score = SCORE_MAX;
      if (ref_left == 0) begin
        ref_clear = 1'b1;
        ref_rem   = 0;
      end else if (pow) begin
        ref_rem = POWER_TICKS;
      end else if (ref_rem > 0) begin
        ref_rem = ref_rem - 1;
      end
    end else if (ref_rem > 0) begin
      ref_rem = ref_rem - 1;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [COLS-1:0] row_exp;
    row_exp = '0;
    if (int'(rd_row) < ROWS) row_exp = ref_map[rd_row];
    check("score",           32'(score),           32'(ref_score));
    check("pellets_left",    32'(pellets_left),    32'(ref_left));
    check("eat_pulse",       32'(eat_pulse),       32'(ref_pulse));
    check("power_mode",      32'(power_mode),      32'(ref_rem > 0));
    check("power_remaining", 32'(power_remaining), 32'(ref_rem));
    check("level_clear",     32'(level_clear),     32'(ref_clear));
    check("rd_pellets",      32'(rd_pellets),      32'(row_exp));
  endtask

  task automatic step(input int x, input int y, input bit nl);
    curr_x     = 5'(x);
    curr_y     = 5'(y);
    next_level = nl;
    rd_row     = 5'($urandom_range(0, 31));
    @(posedge clk2);
    ref_step(x, y, nl);
    #1;
    check_all();
    next_level = 1'b0;
  endtask

  // Reset with the clock parked high, so only the asynchronous path can act.
  task automatic async_reset();
    clk_en = 1'b0;
    #3;
    reset = 1'b1;
    ref_reset();
    #1;
    check("rst_power_mode",  32'(power_mode),  32'(0));
    check("rst_score",       32'(score),       32'(0));
    check("rst_level_clear", 32'(level_clear), 32'(0));
    check("rst_left",        32'(pellets_left), 32'(ref_total));
    check("rst_remaining",   32'(power_remaining), 32'(0));
    check("rst_eat_pulse",   32'(eat_pulse),   32'(0));
    for (int r = 0; r < 24; r++) begin
      rd_row = 5'(r);
      #1;
      check("rst_map_row", 32'(rd_pellets), (r < ROWS) ? 32'(PELLET_MAP[r] | POWER_MAP[r]) : 32'(0));
    end
    reset  = 1'b0;
    #1;
    clk_en = 1'b1;
  endtask

  task automatic play_level(input bit reload_after);
    int q[$];
    int tmp, j;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        if (ref_map[y][x]) q.push_back(y * 32 + x);
    for (int i = q.size() - 1; i > 0; i--) begin
      j    = int'($urandom_range(0, i));
      tmp  = q[i];
      q[i] = q[j];
      q[j] = tmp;
    end
    foreach (q[i]) begin
      if ($urandom_range(0, 3) == 0)
        step(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b0);
      step(q[i] % 32, q[i] / 32, !ref_clear && ($urandom_range(0, 7) == 0));
    end
    check("lvl_clear", 32'(level_clear), 32'(1));
    step(1, 1, 1'b0);
    if (reload_after) step(SPAWN_X, SPAWN_Y, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, pulses, gaps, held;
    bit fell;

    ref_total = 0;
    for (int r = 0; r < ROWS; r++) ref_total += $countones(PELLET_MAP[r] | POWER_MAP[r]);

    #1;
    reset = 1'b1;
    ref_reset();
    #1;
    check_all();
    #6;
    reset = 1'b0;

    // Idle on the pellet-free spawn cell.
    pulses = 0;
    repeat (5) begin
      step(SPAWN_X, SPAWN_Y, 1'b0);
      pulses += int'(eat_pulse);
    end
    check("spawn_pulses", 32'(pulses), 32'(0));
    check("spawn_score",  32'(score),  32'(0));

    // Stand on a regular pellet: eaten exactly once.
    step(1, 1, 1'b0);
    check("first_eat_score", 32'(score), 32'(10));
    check("first_eat_left",  32'(pellets_left), 32'(ref_total - 1));
    pulses = int'(eat_pulse);
    repeat (2) begin
      step(1, 1, 1'b0);
      pulses += int'(eat_pulse);
    end
    check("stand_pulses", 32'(pulses), 32'(1));
    rd_row = 5'd1;
    #1;
    check("row1_bit1", 32'(rd_pellets[1]), 32'(0));

    // Power pellet: frightened for exactly POWER_TICKS cycles.
    step(1, 2, 1'b0);
    check("power_score", 32'(score), 32'(60));
    check("power_load",  32'(power_remaining), 32'(POWER_TICKS));
    hi = int'(power_mode);
    repeat (44) begin
      step(1, 2, 1'b0);
      hi += int'(power_mode);
    end
    check("power_len",     32'(hi), 32'(POWER_TICKS));
    check("power_expired", 32'(power_mode), 32'(0));

    // Second power pellet 20 cycles in reloads the timer.
    async_reset();
    step(1, 2, 1'b0);
    hi = int'(power_mode);
    fell = 1'b0;
    gaps = 0;
    repeat (19) begin
      step(SPAWN_X, SPAWN_Y, 1'b0);
      hi += int'(power_mode);
    end
    step(19, 2, 1'b0);
    check("reload_remaining", 32'(power_remaining), 32'(POWER_TICKS));
    hi += int'(power_mode);
    repeat (50) begin
      step(SPAWN_X, SPAWN_Y, 1'b0);
      hi += int'(power_mode);
      if (!power_mode) fell = 1'b1;
      else if (fell) gaps++;
    end
    check("reload_len",  32'(hi), 32'(20 + POWER_TICKS));
    check("reload_gaps", 32'(gaps), 32'(0));

    // Asynchronous reset in the middle of frightened mode.
    async_reset();
    step(1, 2, 1'b0);
    repeat (5) step(SPAWN_X, SPAWN_Y, 1'b0);
    check("mid_power", 32'(power_mode), 32'(1));
    async_reset();

    // Walk every pellet cell in scan order.
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        if (ref_map[y][x]) step(x, y, 1'b0);
    check("walk_clear", 32'(level_clear),  32'(1));
    check("walk_left",  32'(pellets_left), 32'(0));
    check("walk_power", 32'(power_mode),   32'(0));
    step(19, 17, 1'b0);
    held = ref_score;
    step(SPAWN_X, SPAWN_Y, 1'b1);
    check("next_clear", 32'(level_clear),  32'(0));
    check("next_left",  32'(pellets_left), 32'(ref_total));
    check("next_score", 32'(score),        32'(held));

    // Randomized levels until the score pins at all-ones.
    for (int lvl = 0; lvl < 24; lvl++) play_level(lvl != 23);
    check("score_sat", 32'(score), 32'(SCORE_MAX));
    check("mid_clear", 32'(level_clear), 32'(1));
    async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pellet_tracker.md
Name: pellet_tracker

Overview:
- Sits directly downstream of the Pac-Man movement controller on the clk2 move tick.
- Consumes Pac-Man's cell position and owns the live pellet map.
- Clears pellets as they are eaten, accumulates score, runs the power-pellet (frightened) timer and flags level completion.
- Provides a combinational row read port for the renderer.

Parameters:
- COLS, 21: board width in cells.
- ROWS, 23: board height in cells.
- PELLET_PTS, 10: score added per regular pellet.
- POWER_PTS, 50: score added per power pellet.
- POWER_TICKS, 40: clk2 cycles that power_mode stays high.
- SCORE_W, 16: score width.

Ports:
- clk2 in 1: move-tick clock.
- reset in 1: asynchronous, active-high.
- curr_x in 5: Pac-Man column from the controller.
- curr_y in 5: Pac-Man row from the controller.
- next_level in 1: one-cycle request to reload the board after a clear.
- rd_row in 5: renderer row select.
- rd_pellets out COLS: live pellet bits of rd_row; combinational; 0 if rd_row>=ROWS.
- score out SCORE_W: accumulated score.
- pellets_left out 9: remaining pellets, power pellets included.
- eat_pulse out 1: one-cycle strobe on any pellet eaten.
- power_mode out 1: frightened mode active.
- power_remaining out 6: frightened cycles left.
- level_clear out 1: board empty, waiting for next_level.

Behaviour:
- Reset is asynchronous, active-high; clock is clk2.
- Reset values:
  - map = PELLET_MAP | POWER_MAP.
  - score = 0; pellets_left = TOTAL_PELLETS.
  - eat_pulse = 0; power_mode = 0; power_remaining = 0; level_clear = 0.
  - state = PLAY.
- Sampling: curr_x/curr_y are sampled at each clk2 edge. Map, score, counters and eat_pulse update at that same edge, so the effect appears one clk2 cycle after the position first appears on the inputs.
- Eat condition: state != CLEAR, curr_x<COLS, curr_y<ROWS, and map[curr_y][curr_x]==1.
- On an eat:
  - Clear the map bit.
  - pellets_left decrements by 1.
  - eat_pulse=1 for that cycle only.
  - score += POWER_PTS if POWER_MAP has the bit set, else PELLET_PTS.
- Score saturates at all-ones; it never wraps.
- Pellet-free cells and out-of-range coordinates: no change, eat_pulse=0.
- Pac-Man standing still on a cell: eats it at most once, because the bit is already cleared on the next cycle.
- States: PLAY, POWER, CLEAR. power_mode = (state==POWER); level_clear = (state==CLEAR).
- PLAY → POWER: power pellet eaten and it is not the last pellet; power_remaining ← POWER_TICKS.
- POWER:
  - power_remaining decrements by 1 each cycle.
  - At the edge where it is 1, it goes to 0 and state → PLAY. power_mode is therefore high for exactly POWER_TICKS cycles.
  - A power pellet eaten while in POWER reloads power_remaining to POWER_TICKS, overriding that cycle's decrement.
- PLAY/POWER → CLEAR: the eat drives pellets_left 1→0. This has priority over the power transition; power_remaining ← 0.
- CLEAR: no eating; score holds.
- next_level:
  - In CLEAR: reload both maps, pellets_left ← TOTAL_PELLETS, state → PLAY, score retained.
  - In PLAY/POWER: ignored.
- Reset mid-POWER or mid-CLEAR returns every output to its reset value immediately.

Decomposition:
- Shared package pacman_pkg holds:
  - COLS, ROWS.
  - PELLET_MAP and POWER_MAP (ROWS × COLS bit arrays).
  - TOTAL_PELLETS, a constant population count.
  - SPAWN_X=10, SPAWN_Y=12.
  - The tracker_state_t enum.
- Board layout fixed in that package:
  - Power pellets at (1,2), (19,2), (1,17), (19,17).
  - Regular pellet at (1,1).
  - Spawn cell (10,12) is pellet-free.
- One sub-module: power_timer (load, tick, remaining, active). The pellet map and score logic stay in pellet_tracker.

Test Plan:
- Reset, hold (10,12) for 5 cycles → score=0, pellets_left=TOTAL_PELLETS, eat_pulse never high.
- Drive (1,1) for 3 cycles:
  - One cycle after (1,1) first appears: score=10, pellets_left=TOTAL-1, eat_pulse high for exactly 1 cycle.
  - rd_row=1 → bit1=0.
- Drive (1,2) → score +50, power_mode high for exactly 40 cycles, power_remaining 40→0, then state PLAY.
- Eat (1,2), wait 20 cycles, eat (19,2) → power_remaining reloads to 40; power_mode stays high continuously for 20+40 cycles total.
- Walk the position over every pellet cell:
  - The last eat → level_clear=1, pellets_left=0, power_mode=0.
  - Pulse next_level → level_clear=0, pellets_left=TOTAL, score unchanged.
- Assert reset asynchronously mid-POWER with clk2 stopped → power_mode, score and level_clear drop to 0 immediately; the map is fully restored.
